// File: rtl/gouram_trace_pkg.sv
// Shared definitions for the gouram trace export path: serializer states and
// default geometry shared between the serializer and its FIFO.
package gouram_trace_pkg;

    localparam int TRACE_WIDTH_DEF    = 128;
    localparam int BEAT_WIDTH_DEF     = 32;
    localparam int BEATS_DEF          = TRACE_WIDTH_DEF / BEAT_WIDTH_DEF;
    localparam int FIFO_DEPTH_DEF     = 16;
    localparam int LEVEL_WIDTH_DEF    = $clog2(FIFO_DEPTH_DEF) + 1;
    localparam int DROP_CNT_WIDTH_DEF = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ser_state_e;

endpackage

// File: rtl/gouram_trace_serializer_if.sv
// Beat stream from the trace serializer towards the debug/export port.
interface gouram_trace_serializer_if #(
    parameter int BEAT_WIDTH = 32
);
    logic [BEAT_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_last;
    logic                  m_ready;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/gouram_trace_fifo.sv
// Synchronous record FIFO. A push while full is accepted only when a pop
// frees a slot in the same cycle; a pop while empty is ignored.
module gouram_trace_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok_s, pop_ok_s;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == CNT_W'(0));
    assign pop_ok_s  = pop_i & ~empty_o;
    assign push_ok_s = push_i & (~full_o | pop_ok_s);
    assign data_o    = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Record storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally; the count register alone decides full/empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push_ok_s && !pop_ok_s) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop_ok_s && !push_ok_s) begin
                count_q <= count_q - CNT_W'(1);
            end else begin
                count_q <= count_q;
            end
        end
    end
endmodule

// File: rtl/gouram_trace_serializer.sv
// Captures locked tracer records into a FIFO and streams each one out as
// narrow beats, LS word first. The tracer is never stalled: records that
// find no room are dropped and counted.
module gouram_trace_serializer
    import gouram_trace_pkg::*;
#(
    parameter int TRACE_WIDTH    = TRACE_WIDTH_DEF,
    parameter int BEAT_WIDTH     = BEAT_WIDTH_DEF,
    parameter int FIFO_DEPTH     = FIFO_DEPTH_DEF,
    parameter int DROP_CNT_WIDTH = DROP_CNT_WIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [TRACE_WIDTH-1:0]        trace_data_i,
    input  logic                          trace_capture_enable,
    input  logic                          lock,
    gouram_trace_serializer_if.master     m_if,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [DROP_CNT_WIDTH-1:0]     drop_count,
    input  logic                          clear_overflow
);
    localparam int BEATS = TRACE_WIDTH / BEAT_WIDTH;
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    ser_state_e                             state_q, state_d;
    logic [IDX_W-1:0]                       beat_idx_q, beat_idx_d;
    logic [BEATS-1:0][BEAT_WIDTH-1:0]       shift_q, shift_d;
    logic                                   overflow_q, overflow_d;
    logic [DROP_CNT_WIDTH-1:0]              drop_count_q, drop_count_d;

    logic                                   push_req_s, pop_s, drop_s;
    logic                                   fifo_full_s, fifo_empty_s;
    logic [TRACE_WIDTH-1:0]                 fifo_data_s;
    logic                                   last_beat_s;

    assign push_req_s  = trace_capture_enable & lock;
    assign drop_s      = push_req_s & fifo_full_s & ~pop_s;
    assign last_beat_s = (beat_idx_q == IDX_W'(BEATS - 1));

    gouram_trace_fifo #(
        .WIDTH (TRACE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_req_s),
        .data_i  (trace_data_i),
        .pop_i   (pop_s),
        .data_o  (fifo_data_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_level)
    );

    // Stream outputs come straight from state registers; idle shows zeros.
    assign m_if.m_valid = (state_q == ST_SEND);
    assign m_if.m_data  = (state_q == ST_SEND) ? shift_q[beat_idx_q] : '0;
    assign m_if.m_last  = (state_q == ST_SEND) & last_beat_s;
    assign overflow     = overflow_q;
    assign drop_count   = drop_count_q;

    // Serializer next state: load a record when idle, advance on handshakes,
    // reload back-to-back after the last beat when more records wait.
    always_comb begin
        state_d    = state_q;
        beat_idx_d = beat_idx_q;
        shift_d    = shift_q;
        pop_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s      = 1'b1;
                    shift_d    = fifo_data_s;
                    beat_idx_d = '0;
                    state_d    = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (m_if.m_ready && last_beat_s) begin
                    beat_idx_d = '0;
                    if (!fifo_empty_s) begin
                        pop_s   = 1'b1;
                        shift_d = fifo_data_s;
                        state_d = ST_SEND;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (m_if.m_ready) begin
                    beat_idx_d = beat_idx_q + IDX_W'(1);
                end else begin
                    beat_idx_d = beat_idx_q;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                beat_idx_d = '0;
            end
        endcase
    end

    // Drop accounting: a clear in the same cycle as a drop leaves one drop recorded.
    always_comb begin
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (clear_overflow) begin
            overflow_d   = drop_s;
            drop_count_d = drop_s ? DROP_CNT_WIDTH'(1) : DROP_CNT_WIDTH'(0);
        end else if (drop_s) begin
            overflow_d = 1'b1;
            if (drop_count_q != {DROP_CNT_WIDTH{1'b1}}) begin
                drop_count_d = drop_count_q + DROP_CNT_WIDTH'(1);
            end else begin
                drop_count_d = drop_count_q;
            end
        end else begin
            overflow_d   = overflow_q;
            drop_count_d = drop_count_q;
        end
    end

    // State, shift register and drop-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            beat_idx_q   <= '0;
            shift_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            beat_idx_q   <= beat_idx_d;
            shift_q      <= shift_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end
endmodule

// File: tb/tb_gouram_trace_serializer.sv
// Directed bench for gouram_trace_serializer: capture, streaming order,
// back-pressure, overflow accounting, lock gating and async reset.
module tb_gouram_trace_serializer;

    logic          clk;
    logic          rst_n;
    logic [127:0]  trace_data_i;
    logic          trace_capture_enable;
    logic          lock;
    logic          clear_overflow;
    logic [4:0]    fifo_level;
    logic          overflow;
    logic [15:0]   drop_count;

    gouram_trace_serializer_if #(.BEAT_WIDTH(32)) s_if ();

    gouram_trace_serializer dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .trace_data_i         (trace_data_i),
        .trace_capture_enable (trace_capture_enable),
        .lock                 (lock),
        .m_if                 (s_if),
        .fifo_level           (fifo_level),
        .overflow             (overflow),
        .drop_count           (drop_count),
        .clear_overflow       (clear_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_vec = 0;
    int            n_err = 0;
    logic [127:0]  recs [0:19];
    logic [32:0]   got [$];
    int            first_idx;
    int            last_idx;
    int            max_lvl;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Runs ncyc cycles from a negedge. Captures recs[i] for i<ncap.
    // mode 0: ready high, 1: ready toggles, 2: ready low.
    task automatic stream_run(input int ncap, input int ncyc, input int mode);
        logic        stall;
        logic [31:0] pdata;
        logic        plast;
        stall = 1'b0; pdata = '0; plast = 1'b0;
        got.delete();
        first_idx = -1; last_idx = -1; max_lvl = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
            if (stall) begin
                check_val($sformatf("stall_valid@%0d", i), {127'd0, s_if.m_valid}, 128'd1);
                check_val($sformatf("stall_data@%0d", i), {96'd0, s_if.m_data}, {96'd0, pdata});
                check_val($sformatf("stall_last@%0d", i), {127'd0, s_if.m_last}, {127'd0, plast});
            end
            trace_capture_enable = (i < ncap);
            trace_data_i         = (i < ncap) ? recs[i] : 128'd0;
            s_if.m_ready         = (mode == 0) ? 1'b1 : ((mode == 1) ? ((i % 2) == 0) : 1'b0);
            if (s_if.m_valid && s_if.m_ready) begin
                got.push_back({s_if.m_last, s_if.m_data});
                if (first_idx < 0) first_idx = i;
                last_idx = i;
            end
            stall = s_if.m_valid & ~s_if.m_ready;
            pdata = s_if.m_data;
            plast = s_if.m_last;
            @(negedge clk);
        end
        trace_capture_enable = 1'b0;
    endtask

    task automatic check_beats(input int nrec);
        logic [127:0] r;
        int           n;
        check_val("beat_count", 128'(got.size()), 128'(nrec * 4));
        n = (got.size() < nrec * 4) ? got.size() : nrec * 4;
        for (int k = 0; k < n; k++) begin
            r = recs[k / 4];
            check_val($sformatf("beat%0d_data", k), {96'd0, got[k][31:0]}, {96'd0, r[(k % 4) * 32 +: 32]});
            check_val($sformatf("beat%0d_last", k), {127'd0, got[k][32]}, {127'd0, ((k % 4) == 3)});
        end
    endtask

    initial begin
        rst_n = 1'b0; trace_data_i = '0; trace_capture_enable = 1'b0;
        lock = 1'b1; clear_overflow = 1'b0; s_if.m_ready = 1'b0;
        for (int i = 0; i < 20; i++) recs[i] = {4{32'hA000_0000 + 32'(i * 16)}} + {32'd3, 32'd2, 32'd1, 32'd0};
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check_val("rst_valid", {127'd0, s_if.m_valid}, 128'd0);
        check_val("rst_data", {96'd0, s_if.m_data}, 128'd0);
        check_val("rst_last", {127'd0, s_if.m_last}, 128'd0);
        check_val("rst_level", {123'd0, fifo_level}, 128'd0);
        check_val("rst_ovf", {127'd0, overflow}, 128'd0);
        check_val("rst_drop", {112'd0, drop_count}, 128'd0);

        // 1: single record, latency and beat order
        recs[0] = 128'h01234567_76543210_FEDCBA98_89ABCDEF;
        stream_run(1, 10, 0);
        check_beats(1);
        check_val("t1_first_valid_idx", 128'(first_idx), 128'd2);
        check_val("t1_beat0_word", {96'd0, got[0][31:0]}, 128'h89ABCDEF);

        // 2: three back-to-back records, contiguous 12 beats
        recs[0] = 128'h11111113_11111112_11111111_11111110;
        recs[1] = 128'h22222223_22222222_22222221_22222220;
        recs[2] = 128'h33333333_33333332_33333331_33333330;
        stream_run(3, 18, 0);
        check_beats(3);
        check_val("t2_first_idx", 128'(first_idx), 128'd2);
        check_val("t2_contiguous", 128'(last_idx - first_idx + 1), 128'd12);
        check_val("t2_level_peak", 128'(max_lvl), 128'd2);

        // 3: fill with sink stalled, then clear, then drain in order
        for (int i = 0; i < 20; i++) recs[i] = {4{32'hC000_0000 + 32'(i * 16)}} + {32'd3, 32'd2, 32'd1, 32'd0};
        stream_run(20, 22, 2);
        check_val("t3_level", {123'd0, fifo_level}, 128'd16);
        check_val("t3_drop", {112'd0, drop_count}, 128'd3);
        check_val("t3_ovf", {127'd0, overflow}, 128'd1);
        check_val("t3_valid", {127'd0, s_if.m_valid}, 128'd1);
        check_val("t3_head", {96'd0, s_if.m_data}, {96'd0, recs[0][31:0]});
        clear_overflow = 1'b1; trace_capture_enable = 1'b1; trace_data_i = 128'hDEAD;
        @(negedge clk);
        clear_overflow = 1'b0; trace_capture_enable = 1'b0;
        check_val("t3_clrdrop_cnt", {112'd0, drop_count}, 128'd1);
        check_val("t3_clrdrop_ovf", {127'd0, overflow}, 128'd1);
        check_val("t3_clrdrop_lvl", {123'd0, fifo_level}, 128'd16);
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        check_val("t3_clr_cnt", {112'd0, drop_count}, 128'd0);
        check_val("t3_clr_ovf", {127'd0, overflow}, 128'd0);
        stream_run(0, 75, 0);
        check_beats(17);
        check_val("t3_drain_level", {123'd0, fifo_level}, 128'd0);
        check_val("t3_drain_valid", {127'd0, s_if.m_valid}, 128'd0);

        // 4: ready toggling, stall stability checked inside stream_run
        recs[0] = 128'h44444443_44444442_44444441_44444440;
        recs[1] = 128'h55555553_55555552_55555551_55555550;
        stream_run(2, 30, 1);
        check_beats(2);

        // 5: captures without lock are ignored
        lock = 1'b0;
        stream_run(5, 8, 0);
        check_beats(0);
        check_val("t5_level", {123'd0, fifo_level}, 128'd0);
        check_val("t5_drop", {112'd0, drop_count}, 128'd0);
        lock = 1'b1;

        // 6: async reset mid-record, then clean restart from beat 0
        recs[0] = 128'h66666663_66666662_66666661_66666660;
        s_if.m_ready = 1'b0; trace_capture_enable = 1'b1; trace_data_i = recs[0];
        @(negedge clk);
        trace_capture_enable = 1'b0;
        @(negedge clk);
        s_if.m_ready = 1'b1;
        repeat (2) @(negedge clk);
        s_if.m_ready = 1'b0;
        check_val("t6_beat2_data", {96'd0, s_if.m_data}, 128'h66666662);
        #2 rst_n = 1'b0;
        #1;
        check_val("t6_rst_valid", {127'd0, s_if.m_valid}, 128'd0);
        check_val("t6_rst_data", {96'd0, s_if.m_data}, 128'd0);
        check_val("t6_rst_last", {127'd0, s_if.m_last}, 128'd0);
        check_val("t6_rst_level", {123'd0, fifo_level}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        recs[0] = 128'h77777773_77777772_77777771_77777770;
        stream_run(1, 10, 0);
        check_beats(1);
        check_val("t6_first_idx", 128'(first_idx), 128'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
